outport: RTL and testbench
==========================

// Module: outport
// PURPOSE
//  Transmit side of the router-to-router link. Accepts 48-bit packets from the local crossbar/arbiter,
//  buffers them and drives them onto the inter-router channel with a diff-pair strobe. Downstream
//  buffer space is tracked by a credit counter that is replenished by a diff-pair credit return.
//  One outport sits on each mesh-facing side of the router, wired to the neighbour's inport.
// PARAMETERS
//  CREDITS     4   downstream buffer slots; initial and maximum credit count (>=1)
//  FIFO_DEPTH  2   local packet buffer entries (power of 2, >=2)
// PORTS
//  clka            in   1   clock; single clock domain
//  rsta            in   1   reset, synchronous, active-high
//  packet_din      in   48  packet from crossbar; [47:44]=x dest, [43:40]=y dest
//  valid_din       in   1   packet_din valid this cycle
//  ready_dout      out  1   outport accepts packet_din this cycle
//  credit_din      in   2   credit return {p,n} from downstream
//  channel_dout    out  48  packet toward neighbour; registered
//  diff_pair_dout  out  2   transfer strobe {p,n}; registered
//  credit_err_dout out  1   credit overflow flag; present only with OUTPORT_CREDIT_CHECK_EN
// BEHAVIOUR
//  Diff-pair encoding (both directions): 2'b10 = strobe, 2'b01 = idle; 2'b00/2'b11 are illegal and treated as idle.
//  Reset (rsta=1 at a clock edge, also mid-operation): FIFO flushed, credits=CREDITS, state=IDLE,
//   channel_dout=48'b0, diff_pair_dout=2'b01, ready_dout=0 during reset and 1 from the first cycle after it,
//   credit_err_dout=0. In-flight packets are dropped and no strobe is emitted.
//  Accept: push when valid_din && ready_dout. ready_dout = !full (combinational from occupancy only, not from valid_din).
//  Send: when FIFO non-empty && credits>0, register head into channel_dout, drive diff_pair_dout=2'b10 for exactly one
//   cycle, pop, credits-1. Otherwise diff_pair_dout=2'b01 and channel_dout holds its last value.
//  Latency: a packet accepted into an empty FIFO with credits>0 at edge N appears on channel_dout with strobe after edge N+1.
//   Back-to-back strobes are allowed, so throughput is 1 packet/cycle while credits last.
//  Credit return: credit_din==2'b10 sampled at an edge -> credits+1. Simultaneous send and return -> credits unchanged.
//   Counter width $clog2(CREDITS+1); it saturates at CREDITS and never wraps.
//  FIFO: pointers wrap modulo FIFO_DEPTH. Push and pop in the same cycle on a full FIFO: pop frees a slot, but ready_dout
//   was already 0, so no push occurs. Same-cycle push and pop on an empty FIFO: the packet is not bypassed (latency rule holds).
//  FSM (registered, 2-bit):
//   IDLE  : FIFO empty. Go to SEND on push if credits>0, else STALL.
//   SEND  : strobing. Stay while FIFO non-empty after the pop and credits>0; go to IDLE if empty; go to STALL if credits==0.
//   STALL : FIFO non-empty, credits==0. Go to SEND when a credit returns (the send occurs the next cycle).
//  Packet fields are never modified; routing is done upstream.
// CONFIGURATION
//  `OUTPORT_CREDIT_CHECK_EN defined: a credit return while credits==CREDITS sets credit_err_dout=1 (sticky until rsta);
//   the count stays saturated.
//  Not defined: credit_err_dout port is absent and the excess credit is silently ignored (saturation only).
// STRUCTURE
//  Shared package atto_noc_pkg: PKT_W=48, X_MSB/X_LSB=47/44, Y_MSB/Y_LSB=43/40, DP_STROBE=2'b10,
//   DP_IDLE=2'b01, outport state encoding (IDLE/SEND/STALL).
//  Sub-module output_flow_handler: credit counter, credit_din decode, diff_pair_dout encode, overflow check.
//   outport owns the FIFO, the FSM and the channel register.
// TESTING
//  1 Reset, then push 0xAB_CDEF_0123_45 at edge N -> channel_dout equals it with diff_pair_dout=2'b10 after N+1,
//    2'b01 after N+2; credits=3.
//  2 With no credit return, push 6 packets back-to-back -> 4 strobes on consecutive cycles, FSM in STALL, FIFO holds 2
//    and ready_dout=0; one credit_din=2'b10 -> exactly one more strobe.
//  3 Credit return in the same cycle as a send with credits=2 -> credits stay 2; no loss or double-count.
//  4 Assert rsta for 1 cycle while STALL with 2 queued -> no strobe; credits=4, FIFO empty, diff_pair_dout=2'b01,
//    channel_dout=0.
//  5 Credit return at credits==4: with OUTPORT_CREDIT_CHECK_EN, credit_err_dout=1 until reset; without it, no flag
//    and credits=4.
//  6 Drive credit_din=2'b11 and 2'b00 for 3 cycles each -> credits unchanged, no error flag.

Source files
------------

// File: rtl/atto_noc_pkg.sv
// atto_noc_pkg: shared router-link constants and outport state encoding
//   PKT_W            packet width
//   X_MSB..Y_LSB     destination coordinate fields inside a packet
//   DP_STROBE/IDLE   diff-pair {p,n} encodings
//   outport_state_e  outport FSM states
package atto_noc_pkg;
    localparam int PKT_W = 48;
    localparam int X_MSB = 47;
    localparam int X_LSB = 44;
    localparam int Y_MSB = 43;
    localparam int Y_LSB = 40;
    localparam logic [1:0] DP_STROBE = 2'b10;
    localparam logic [1:0] DP_IDLE = 2'b01;
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, STALL = 2'd2} outport_state_e;
endpackage

// File: rtl/output_flow_handler.sv
// output_flow_handler: downstream credit counter and diff-pair strobe encoder
//   clka_i       clock
//   rsta_i       synchronous active-high reset
//   credit_i     diff-pair credit return {p,n}
//   send_i       a packet leaves this cycle (only asserted when credits > 0)
//   credits_d_o  credit count after this edge
//   dp_o         registered transfer strobe {p,n}
//   err_o        sticky credit overflow flag (OUTPORT_CREDIT_CHECK_EN only)
module output_flow_handler
    import atto_noc_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int CW = $clog2(CREDITS + 1)
) (
    input  logic          clka_i,
    input  logic          rsta_i,
    input  logic [1:0]    credit_i,
    input  logic          send_i,
    output logic [CW-1:0] credits_d_o,
    output logic [1:0]    dp_o
`ifdef OUTPORT_CREDIT_CHECK_EN
    ,
    output logic          err_o
`endif
);
    localparam int CW1 = CW + 1;
    localparam logic [CW-1:0] CMAX = CREDITS[CW-1:0];
    logic [CW-1:0] credits_q;
    logic [CW:0] sum;
    logic [1:0] dp_q;
    logic ret;
    // illegal 2'b00/2'b11 decode as idle
    assign ret = credit_i == DP_STROBE;
    // send implies credits_q > 0, so the sum never underflows
    assign sum = {1'b0, credits_q} + CW1'(ret) - CW1'(send_i);
    assign credits_d_o = sum > {1'b0, CMAX} ? CMAX : sum[CW-1:0];
    assign dp_o = dp_q;
    always_ff @(posedge clka_i) begin
        if (rsta_i) begin
            credits_q <= CMAX;
            dp_q <= DP_IDLE;
        end else begin
            credits_q <= credits_d_o;
            dp_q <= send_i ? DP_STROBE : DP_IDLE;
        end
    end
`ifdef OUTPORT_CREDIT_CHECK_EN
    logic err_q;
    always_ff @(posedge clka_i) begin
        if (rsta_i) err_q <= 1'b0;
        else if (ret && credits_q == CMAX) err_q <= 1'b1;
    end
    assign err_o = err_q;
`endif
endmodule

// File: rtl/outport.sv
// outport: router-link transmitter with packet FIFO and credit-based flow control
//   clka            clock
//   rsta            synchronous active-high reset
//   packet_din      packet from crossbar
//   valid_din       packet_din valid
//   ready_dout      packet accepted this cycle when valid_din
//   credit_din      diff-pair credit return {p,n}
//   channel_dout    registered packet toward neighbour
//   diff_pair_dout  registered transfer strobe {p,n}
//   credit_err_dout sticky credit overflow (only with OUTPORT_CREDIT_CHECK_EN)
module outport
    import atto_noc_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic [PKT_W-1:0] packet_din,
    input  logic             valid_din,
    output logic             ready_dout,
    input  logic [1:0]       credit_din,
    output logic [PKT_W-1:0] channel_dout,
    output logic [1:0]       diff_pair_dout
`ifdef OUTPORT_CREDIT_CHECK_EN
    ,
    output logic             credit_err_dout
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int AW1 = AW + 1;
    localparam int CW = $clog2(CREDITS + 1);
    logic [PKT_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q, cnt_d;
    logic [PKT_W-1:0] chan_q;
    logic [CW-1:0] credits_d;
    outport_state_e state_q, state_d;
    logic push, pop;
    assign ready_dout = !rsta && cnt_q != AW1'(FIFO_DEPTH);
    assign push = valid_din && ready_dout;
    // SEND is held exactly when the FIFO is non-empty and credits remain,
    // so the registered state alone decides the send without bypassing pushes
    assign pop = state_q == SEND;
    assign cnt_d = cnt_q + AW1'(push) - AW1'(pop);
    assign channel_dout = chan_q;
    always_comb begin
        state_d = IDLE;
        state_d = cnt_d == '0 ? IDLE : (credits_d == '0 ? STALL : SEND);
    end
    always_ff @(posedge clka) begin
        if (push) mem_q[wr_q] <= packet_din;
    end
    always_ff @(posedge clka) begin
        if (rsta) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            chan_q <= '0;
            state_q <= IDLE;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            if (pop) chan_q <= mem_q[rd_q];
            cnt_q <= cnt_d;
            state_q <= state_d;
        end
    end
    output_flow_handler #(.CREDITS(CREDITS)) u_flow (
        .clka_i      (clka),
        .rsta_i      (rsta),
        .credit_i    (credit_din),
        .send_i      (pop),
        .credits_d_o (credits_d),
        .dp_o        (diff_pair_dout)
`ifdef OUTPORT_CREDIT_CHECK_EN
        ,
        .err_o       (credit_err_dout)
`endif
    );
endmodule

// File: tb/tb_outport.sv
// tb_outport: randomized and directed check of outport against a queue-based link model
module tb_outport;
    localparam int CR = 4;
    localparam int FD = 2;
    logic clka = 1'b0;
    logic rsta = 1'b1;
    logic valid_din = 1'b0;
    logic [47:0] packet_din = '0;
    logic [1:0] credit_din = 2'b01;
    logic ready_dout;
    logic [47:0] channel_dout;
    logic [1:0] diff_pair_dout;
`ifdef OUTPORT_CREDIT_CHECK_EN
    logic credit_err_dout;
    logic m_err = 1'b0;
`endif
    int n_cmp = 0;
    int n_err = 0;
    int n_strobe = 0;
    logic [47:0] mq[$];
    int m_cred = CR;
    logic [47:0] m_ch = '0;
    logic [1:0] m_dp = 2'b01;

    always #5 clka = ~clka;

    outport dut (
        .clka           (clka),
        .rsta           (rsta),
        .packet_din     (packet_din),
        .valid_din      (valid_din),
        .ready_dout     (ready_dout),
        .credit_din     (credit_din),
        .channel_dout   (channel_dout),
        .diff_pair_dout (diff_pair_dout)
`ifdef OUTPORT_CREDIT_CHECK_EN
        ,
        .credit_err_dout(credit_err_dout)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one cycle: drive at negedge, advance the model at the edge, compare at the next negedge
    task automatic step(input logic v, input logic [47:0] p, input logic [1:0] cr, input logic r);
        bit snd, psh;
        valid_din = v;
        packet_din = p;
        credit_din = cr;
        rsta = r;
        #1 check("ready", 64'(ready_dout), 64'(!r && mq.size() < FD));
        @(posedge clka);
        if (r) begin
            mq.delete();
            m_cred = CR;
            m_ch = '0;
            m_dp = 2'b01;
`ifdef OUTPORT_CREDIT_CHECK_EN
            m_err = 1'b0;
`endif
        end else begin
            snd = mq.size() > 0 && m_cred > 0;
            psh = v && mq.size() < FD;
`ifdef OUTPORT_CREDIT_CHECK_EN
            if (cr == 2'b10 && m_cred == CR) m_err = 1'b1;
`endif
            if (snd) begin
                m_ch = mq.pop_front();
                m_dp = 2'b10;
            end else m_dp = 2'b01;
            if (psh) mq.push_back(p);
            m_cred = m_cred - int'(snd) + int'(cr == 2'b10);
            if (m_cred > CR) m_cred = CR;
        end
        @(negedge clka);
        check("dp", 64'(diff_pair_dout), 64'(m_dp));
        check("chan", 64'(channel_dout), 64'(m_ch));
`ifdef OUTPORT_CREDIT_CHECK_EN
        check("err", 64'(credit_err_dout), 64'(m_err));
`endif
        if (diff_pair_dout == 2'b10) n_strobe++;
    endtask

    task automatic idle(input int n, input logic [1:0] cr);
        for (int i = 0; i < n; i++) step(1'b0, '0, cr, 1'b0);
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 48'h1000 + 48'(i), 2'b01, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, '0, 2'b01, 1'b1);
        n_strobe = 0;
    endtask

    initial begin
        logic [63:0] rnd;
        int x;
        logic [1:0] cr;
        @(negedge clka);
        do_reset();
        do_reset();
        check("rst_chan", 64'(channel_dout), 64'h0);
        check("rst_dp", 64'(diff_pair_dout), 64'h1);
        // single packet latency
        step(1'b1, 48'hABCDEF012345, 2'b01, 1'b0);
        check("t1_nostrobe", 64'(diff_pair_dout), 64'h1);
        idle(1, 2'b01);
        check("t1_chan", 64'(channel_dout), 64'hABCDEF012345);
        check("t1_strobe", 64'(diff_pair_dout), 64'h2);
        idle(1, 2'b01);
        check("t1_idle", 64'(diff_pair_dout), 64'h1);
        // credit exhaustion and one return
        do_reset();
        burst(6);
        idle(4, 2'b01);
        check("t2_strobes", 64'(n_strobe), 64'd4);
        check("t2_full", 64'(ready_dout), 64'h0);
        idle(1, 2'b10);
        idle(3, 2'b01);
        check("t2_one_more", 64'(n_strobe), 64'd5);
        // reset while stalled with packets queued
        n_strobe = 0;
        step(1'b0, '0, 2'b01, 1'b1);
        idle(4, 2'b01);
        check("t4_nostrobe", 64'(n_strobe), 64'd0);
        check("t4_chan", 64'(channel_dout), 64'h0);
        // return concurrent with a send
        do_reset();
        step(1'b1, 48'hA, 2'b01, 1'b0);
        step(1'b1, 48'hB, 2'b01, 1'b0);
        step(1'b0, '0, 2'b10, 1'b0);
        burst(6);
        idle(4, 2'b01);
        check("t3_strobes", 64'(n_strobe), 64'd5);
        // overflow return at full credits saturates
        do_reset();
        idle(1, 2'b10);
        burst(6);
        idle(4, 2'b01);
        check("t5_sat", 64'(n_strobe), 64'd4);
`ifdef OUTPORT_CREDIT_CHECK_EN
        check("t5_err", 64'(credit_err_dout), 64'h1);
`endif
        // illegal diff-pair codes are idle
        do_reset();
        idle(3, 2'b11);
        idle(3, 2'b00);
        burst(6);
        idle(4, 2'b01);
        check("t6_strobes", 64'(n_strobe), 64'd4);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rnd = {$urandom(), $urandom()};
            x = $urandom_range(9);
            cr = x < 3 ? 2'b10 : x < 8 ? 2'b01 : x == 8 ? 2'b00 : 2'b11;
            step($urandom_range(9) < 6, rnd[47:0], cr, $urandom_range(99) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
